// File: rtl/ascon_hash_sequencer.sv
// ----------------------------------------------------------------------------
// ascon_hash_sequencer
//
// Drives a bit-serial, masked Ascon hash core on behalf of a host.
// A host message is captured in IDLE and then streamed MSB first into the
// core over MAX load cycles. Each load cycle also carries 10 fresh
// randomness bits from a 32-bit Galois LFSR. The sequencer then pulses the
// core start and waits for core ready, bounded by TIMEOUT cycles. After GAP
// idle cycles it reads L serial hash bits LSB first and presents the result
// to the host until the host accepts it.
//
// All outputs are registered. They are computed from the state being
// entered, so each output changes on the same edge as the state.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   msg_validxSI     host message valid
//   msg_dataxDI      host message, Y bits, sent MSB first
//   msg_readyxSO     sequencer can accept a message (IDLE)
//   hash_validxSO    hash result valid (HOLD)
//   hash_dataxDO     hash result, L bits
//   hash_readyxSI    host accepts the hash
//   busyxSO          sequencer is not in IDLE
//   errorxSO         sticky core-timeout flag, cleared by the next accept
//   core_messagexSO  [0] message bit, [2:1] randomness
//   core_r64xSO      core randomness
//   core_rfaultxSO   core fault randomness
//   core_startxSO    core start, high for START_CYC cycles
//   core_hashxSI     serial hash bit from the core
//   core_readyxSI    core done, only looked at while waiting
// ----------------------------------------------------------------------------
module ascon_hash_sequencer #(
   parameter int          Y         = 80,
   parameter int          L         = 256,
   parameter int          MAX       = 256,
   parameter int          GAP       = 4,
   parameter int          START_CYC = 3,
   parameter int          TIMEOUT   = 4095,
   parameter logic [31:0] SEED      = 32'hACE1_0001
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         msg_validxSI,
   input  logic [Y-1:0] msg_dataxDI,
   output logic         msg_readyxSO,
   output logic         hash_validxSO,
   output logic [L-1:0] hash_dataxDO,
   input  logic         hash_readyxSI,
   output logic         busyxSO,
   output logic         errorxSO,
   output logic [2:0]   core_messagexSO,
   output logic [6:0]   core_r64xSO,
   output logic         core_rfaultxSO,
   output logic         core_startxSO,
   input  logic         core_hashxSI,
   input  logic         core_readyxSI
);

   // A single counter serves every timed state, so it is sized for the
   // longest of them and never wraps.
   localparam int TOP1 = (MAX > L) ? MAX : L;
   localparam int TOP2 = (TOP1 > TIMEOUT) ? TOP1 : TIMEOUT;
   localparam int TOP3 = (TOP2 > GAP) ? TOP2 : GAP;
   localparam int TOP4 = (TOP3 > START_CYC) ? TOP3 : START_CYC;
   localparam int CW   = $clog2(TOP4 + 1);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t LOAD_LAST  = cnt_t'(MAX - 1);
   localparam cnt_t START_LAST = cnt_t'(START_CYC - 1);
   localparam cnt_t WAIT_LAST  = cnt_t'(TIMEOUT - 1);
   localparam cnt_t GAP_LAST   = cnt_t'((GAP > 0) ? GAP - 1 : 0);
   localparam cnt_t READ_LAST  = cnt_t'(L - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_GAP,
      S_READ,
      S_HOLD
   } state_t;

   state_t        state;
   state_t        state_n;
   cnt_t          cnt;
   cnt_t          cnt_n;
   logic          accept;
   logic          timeout;
   logic [31:0]   lfsr;
   logic [31:0]   lfsr_n;
   logic [Y-1:0]  msg_sh;

   // Galois LFSR, polynomial x^32 + x^22 + x^2 + x + 1, shifting right.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      logic [31:0] n;
      n = {1'b0, s[31:1]};
      if (s[0]) begin
         n = n ^ 32'h8020_0003;
      end
      return n;
   endfunction

   assign lfsr_n = lfsr_step(lfsr);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      timeout = 1'b0;
      case (state)
         S_IDLE: begin
            if (msg_validxSI && msg_readyxSO) begin
               accept  = 1'b1;
               cnt_n   = '0;
               state_n = S_LOAD;
            end
         end
         S_LOAD: begin
            if (cnt == LOAD_LAST) begin
               cnt_n   = '0;
               state_n = S_START;
            end else begin
               cnt_n = cnt + cnt_t'(1);
            end
         end
         S_START: begin
            if (cnt == START_LAST) begin
               cnt_n   = '0;
               state_n = S_WAIT;
            end else begin
               cnt_n = cnt + cnt_t'(1);
            end
         end
         S_WAIT: begin
            // Ready on the last allowed cycle still counts as success.
            if (core_readyxSI) begin
               cnt_n   = '0;
               state_n = (GAP == 0) ? S_READ : S_GAP;
            end else if (cnt == WAIT_LAST) begin
               timeout = 1'b1;
               cnt_n   = '0;
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt + cnt_t'(1);
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_n   = '0;
               state_n = S_READ;
            end else begin
               cnt_n = cnt + cnt_t'(1);
            end
         end
         S_READ: begin
            if (cnt == READ_LAST) begin
               cnt_n   = '0;
               state_n = S_HOLD;
            end else begin
               cnt_n = cnt + cnt_t'(1);
            end
         end
         S_HOLD: begin
            if (hash_readyxSI) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = S_IDLE;
         end
      endcase
   end

   // Message shift register holds the bits still to be sent. Zeros shift in
   // behind the message, which pads the load window past Y.
   always_ff @(posedge clk) begin
      if (accept) begin
         msg_sh <= msg_dataxDI << 1;
      end else if (state == S_LOAD) begin
         msg_sh <= msg_sh << 1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         cnt             <= '0;
         lfsr            <= SEED;
         msg_readyxSO    <= 1'b0;
         busyxSO         <= 1'b0;
         errorxSO        <= 1'b0;
         hash_validxSO   <= 1'b0;
         hash_dataxDO    <= '0;
         core_messagexSO <= '0;
         core_r64xSO     <= '0;
         core_rfaultxSO  <= 1'b0;
         core_startxSO   <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         msg_readyxSO  <= (state_n == S_IDLE);
         busyxSO       <= (state_n != S_IDLE);
         core_startxSO <= (state_n == S_START);
         hash_validxSO <= (state_n == S_HOLD);

         if (accept) begin
            errorxSO <= 1'b0;
         end else if (timeout) begin
            errorxSO <= 1'b1;
         end

         // The LFSR only moves in load cycles, so every load cycle gets new
         // randomness and the sequence is reproducible from SEED.
         if (state_n == S_LOAD) begin
            lfsr <= lfsr_n;
            {core_rfaultxSO, core_r64xSO, core_messagexSO[2:1]} <= lfsr_n[9:0];
            core_messagexSO[0] <= accept ? msg_dataxDI[Y-1] : msg_sh[Y-1];
         end else begin
            core_messagexSO <= '0;
            core_r64xSO     <= '0;
            core_rfaultxSO  <= 1'b0;
         end

         // The first bit read ends up in bit 0 after L right shifts.
         if (state == S_READ) begin
            hash_dataxDO <= {core_hashxSI, hash_dataxDO[L-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_ascon_hash_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ascon_hash_sequencer
//
// Directed bench for ascon_hash_sequencer with default parameters. A host
// and a simple core model are driven cycle by cycle from one initial block.
// Expected load words, made of randomness plus a message bit, and expected
// hash results are queued when the stimulus is applied. They are then
// popped and compared as the design presents them.
// ----------------------------------------------------------------------------
module tb_ascon_hash_sequencer;

   localparam int          Y         = 80;
   localparam int          L         = 256;
   localparam int          MAX       = 256;
   localparam int          GAP       = 4;
   localparam int          START_CYC = 3;
   localparam int          TIMEOUT   = 4095;
   localparam logic [31:0] SEED      = 32'hACE1_0001;

   logic         clk = 1'b0;
   logic         rst;
   logic         msg_validxSI;
   logic [Y-1:0] msg_dataxDI;
   logic         msg_readyxSO;
   logic         hash_validxSO;
   logic [L-1:0] hash_dataxDO;
   logic         hash_readyxSI;
   logic         busyxSO;
   logic         errorxSO;
   logic [2:0]   core_messagexSO;
   logic [6:0]   core_r64xSO;
   logic         core_rfaultxSO;
   logic         core_startxSO;
   logic         core_hashxSI;
   logic         core_readyxSI;

   logic [10:0]  core_obs;
   assign core_obs = {core_rfaultxSO, core_r64xSO, core_messagexSO};

   int errors = 0;
   int checks = 0;

   logic [10:0]  load_q[$];
   logic [L-1:0] hash_q[$];
   logic [9:0]   run1_rand[MAX];
   logic [31:0]  model_lfsr;
   logic [Y-1:0] msg_a;
   logic [Y-1:0] msg_b;
   logic [10:0]  exp_load;
   logic [L-1:0] exp_hash;
   logic [L-1:0] five_pattern;
   logic [7:0]   first8;

   always #5 clk = ~clk;

   ascon_hash_sequencer #(
      .Y(Y), .L(L), .MAX(MAX), .GAP(GAP), .START_CYC(START_CYC),
      .TIMEOUT(TIMEOUT), .SEED(SEED)
   ) dut (
      .clk(clk),
      .rst(rst),
      .msg_validxSI(msg_validxSI),
      .msg_dataxDI(msg_dataxDI),
      .msg_readyxSO(msg_readyxSO),
      .hash_validxSO(hash_validxSO),
      .hash_dataxDO(hash_dataxDO),
      .hash_readyxSI(hash_readyxSI),
      .busyxSO(busyxSO),
      .errorxSO(errorxSO),
      .core_messagexSO(core_messagexSO),
      .core_r64xSO(core_r64xSO),
      .core_rfaultxSO(core_rfaultxSO),
      .core_startxSO(core_startxSO),
      .core_hashxSI(core_hashxSI),
      .core_readyxSI(core_readyxSI)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
   function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
      logic [31:0] t;
      t = s >> 1;
      if (s[0]) t = t ^ 32'h8020_0003;
      return t;
   endfunction

   task automatic push_load(input logic [Y-1:0] m);
      logic mb;
      for (int i = 0; i < MAX; i++) begin
         model_lfsr = lfsr_adv(model_lfsr);
         mb = 1'b0;
         if (i < Y) mb = m[Y-1-i];
         load_q.push_back({model_lfsr[9:0], mb});
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_msg_ready"}, 256'(msg_readyxSO), 256'(0));
      chk({tag, "_busy"}, 256'(busyxSO), 256'(0));
      chk({tag, "_error"}, 256'(errorxSO), 256'(0));
      chk({tag, "_hash_valid"}, 256'(hash_validxSO), 256'(0));
      chk({tag, "_hash_data"}, 256'(hash_dataxDO), 256'(0));
      chk({tag, "_core_start"}, 256'(core_startxSO), 256'(0));
      chk({tag, "_core_out"}, 256'(core_obs), 256'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      msg_a         = 80'h656e6372797074696f6e;
      msg_b         = 80'h0123456789abcdef5a5a;
      five_pattern  = {64{4'h5}};
      rst           = 1'b1;
      msg_validxSI  = 1'b0;
      msg_dataxDI   = '0;
      hash_readyxSI = 1'b0;
      core_hashxSI  = 1'b0;
      core_readyxSI = 1'b0;
      model_lfsr    = SEED;
      first8        = '0;

      // reset state
      repeat (3) step();
      chk_reset_outputs("reset");
      rst = 1'b0;
      step();
      chk("release_msg_ready", 256'(msg_readyxSO), 256'(1));
      chk("release_busy", 256'(busyxSO), 256'(0));

      // run 1: full hash with ready and message noise injected during load
      push_load(msg_a);
      msg_dataxDI  = msg_a;
      msg_validxSI = 1'b1;
      step();
      msg_validxSI = 1'b0;
      chk("accept_busy", 256'(busyxSO), 256'(1));
      chk("accept_msg_ready", 256'(msg_readyxSO), 256'(0));
      for (int i = 0; i < MAX; i++) begin
         exp_load = load_q.pop_front();
         run1_rand[i] = exp_load[10:1];
         chk("load", 256'(core_obs), 256'(exp_load));
         chk("load_start", 256'(core_startxSO), 256'(0));
         if (i < 8) first8 = {first8[6:0], core_messagexSO[0]};
         core_readyxSI = (i == 50);
         msg_validxSI  = (i >= 10 && i < 13);
         msg_dataxDI   = ~msg_a;
         step();
      end
      core_readyxSI = 1'b0;
      msg_validxSI  = 1'b0;
      chk("first8_bits", 256'(first8), 256'(8'b0110_0101));
      for (int j = 0; j < START_CYC; j++) begin
         chk("start_high", 256'(core_startxSO), 256'(1));
         chk("start_core_out", 256'(core_obs), 256'(0));
         step();
      end
      chk("start_low", 256'(core_startxSO), 256'(0));
      repeat (40 - START_CYC) step();

      // core model: ready for one cycle, then bit k[0] where k counts from
      // the ready cycle; a stray ready pulse arrives during read
      exp_hash = '0;
      for (int j = 0; j < L; j++) exp_hash[j] = ((1 + GAP + j) % 2) == 1;
      hash_q.push_back(exp_hash);
      for (int k = 0; k <= GAP + L; k++) begin
         core_readyxSI = (k == 0) || (k == 100);
         core_hashxSI  = k[0];
         if (k == GAP + L) chk("valid_early", 256'(hash_validxSO), 256'(0));
         step();
      end
      core_readyxSI = 1'b0;
      core_hashxSI  = 1'b0;
      chk("valid_on_time", 256'(hash_validxSO), 256'(1));
      exp_hash = hash_q.pop_front();
      chk("hash_data", 256'(hash_dataxDO), 256'(exp_hash));
      chk("hash_pattern", 256'(hash_dataxDO), 256'(five_pattern));

      // hold while the host stalls
      for (int j = 0; j < 20; j++) begin
         chk("hold_valid", 256'(hash_validxSO), 256'(1));
         chk("hold_data", 256'(hash_dataxDO), 256'(exp_hash));
         step();
      end
      hash_readyxSI = 1'b1;
      step();
      hash_readyxSI = 1'b0;
      chk("release_valid", 256'(hash_validxSO), 256'(0));
      chk("idle_msg_ready", 256'(msg_readyxSO), 256'(1));
      chk("idle_busy", 256'(busyxSO), 256'(0));

      // run 2: core never answers
      msg_dataxDI  = msg_b;
      msg_validxSI = 1'b1;
      step();
      msg_validxSI = 1'b0;
      chk("run2_busy", 256'(busyxSO), 256'(1));
      repeat (MAX) step();
      chk("run2_start", 256'(core_startxSO), 256'(1));
      repeat (START_CYC) step();
      repeat (TIMEOUT - 1) step();
      chk("wait_last_error", 256'(errorxSO), 256'(0));
      chk("wait_last_busy", 256'(busyxSO), 256'(1));
      step();
      chk("timeout_error", 256'(errorxSO), 256'(1));
      chk("timeout_busy", 256'(busyxSO), 256'(0));
      chk("timeout_msg_ready", 256'(msg_readyxSO), 256'(1));

      // run 3: accept clears the error, then reset mid-load
      msg_dataxDI  = msg_a;
      msg_validxSI = 1'b1;
      step();
      msg_validxSI = 1'b0;
      chk("error_cleared", 256'(errorxSO), 256'(0));
      repeat (100) step();
      rst = 1'b1;
      step();
      chk_reset_outputs("midload_rst");
      rst = 1'b0;
      step();
      chk("post_rst_msg_ready", 256'(msg_readyxSO), 256'(1));

      // run 4: reload after reset must repeat run 1 exactly
      model_lfsr = SEED;
      push_load(msg_a);
      msg_dataxDI  = msg_a;
      msg_validxSI = 1'b1;
      step();
      msg_validxSI = 1'b0;
      for (int i = 0; i < MAX; i++) begin
         exp_load = load_q.pop_front();
         chk("reload", 256'(core_obs), 256'(exp_load));
         chk("rand_repeat", 256'(core_obs[10:1]), 256'(run1_rand[i]));
         step();
      end
      chk("reload_start", 256'(core_startxSO), 256'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
